phy_rx_serial_paralelo: RTL and testbench

Receive-side serial-to-parallel converter for the 4-lane PHY. It is the counterpart of the transmit serializer, which emits one bit per clock, MSB first, and sends the comma byte 8'hBC whenever no valid data is present. The block hunts for byte alignment on the comma and declares the link active after a run of consecutive commas. It then delivers each non-comma byte with a one-cycle valid pulse and the lane index it belongs to, so the downstream demux can rebuild lanes 0–3.

---
 rtl/phy_pkg.sv | 7 +
 rtl/phy_rx_comma_detect.sv | 29 ++
 rtl/phy_rx_serial_paralelo.sv | 71 +++++++
 tb/tb_phy_rx_serial_paralelo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// phy_pkg: constants and state encoding shared by the PHY transmit and receive paths.
package phy_pkg;
    localparam logic [7:0] COMMA         = 8'hBC;
    localparam int         NUM_LANES_DEF = 4;
    localparam int         BC_REQ_DEF    = 4;
    typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} rx_state_t;
endpackage

// File: rtl/phy_rx_comma_detect.sv
// phy_rx_comma_detect: serial history, byte window compare and byte-boundary timing.
module phy_rx_comma_detect
    import phy_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    input  logic       align,
    input  logic       locked,
    output logic [7:0] window,
    output logic       is_comma,
    output logic       boundary
);
    // Only seven history bits are stored; the eighth bit of the window is the live input.
    logic [6:0] sr;
    logic [2:0] bit_cnt;
    assign window   = {sr, data_in};
    assign is_comma = window == COMMA;
    assign boundary = locked && bit_cnt == 3'd7;
    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else begin
            sr      <= window[6:0];
            bit_cnt <= align ? 3'd0 : bit_cnt + 3'd1;
        end
    end
endmodule

// File: rtl/phy_rx_serial_paralelo.sv
// phy_rx_serial_paralelo: comma-aligned serial-to-parallel receiver that tags each
// delivered byte with the lane it was striped onto by the transmitter.
module phy_rx_serial_paralelo
    import phy_pkg::*;
#(
    parameter  int BC_REQ    = BC_REQ_DEF,
    parameter  int NUM_LANES = NUM_LANES_DEF,
    localparam int LW        = $clog2(NUM_LANES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_in,
    output logic [7:0]    data_out,
    output logic          valid_out,
    output logic [LW-1:0] lane_out,
    output logic          active
);
    rx_state_t     state;
    logic [3:0]    bc_cnt;
    logic [LW-1:0] lane_cnt;
    logic [7:0]    window;
    logic          is_comma;
    logic          boundary;
    phy_rx_comma_detect u_det (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .align    (state == SEARCH && is_comma),
        .locked   (state != SEARCH),
        .window   (window),
        .is_comma (is_comma),
        .boundary (boundary)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            bc_cnt    <= '0;
            lane_cnt  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            lane_out  <= '0;
            active    <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                SEARCH: if (is_comma) begin
                    bc_cnt <= 4'd1;
                    state  <= SYNC;
                end
                SYNC: if (boundary) begin
                    bc_cnt <= is_comma ? bc_cnt + 4'd1 : 4'd0;
                    if (!is_comma)
                        state <= SEARCH;
                    else if (bc_cnt + 4'd1 == 4'(BC_REQ)) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                    end
                end
                default: if (boundary) begin
                    // Lock is held until reset; a comma only realigns the lane stripe.
                    lane_cnt <= is_comma ? '0 : lane_cnt + 1'b1;
                    if (!is_comma) begin
                        data_out  <= window;
                        valid_out <= 1'b1;
                        lane_out  <= lane_cnt;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_phy_rx_serial_paralelo.sv
// tb_phy_rx_serial_paralelo: directed and randomized streams checked every clock
// against a bit-stream reference model of the receiver.
module tb_phy_rx_serial_paralelo;
    localparam int         BC_REQ = 4;
    localparam int         NL     = 4;
    localparam logic [7:0] BC     = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic [1:0] lane_out;
    logic       active;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: alignment is an anchor edge index, boundaries are multiples of 8 from it
    int         n, anchor, mode, cnt, lane, pulses;
    logic [7:0] win, e_data;
    logic       e_valid;
    logic [1:0] e_lane;

    phy_rx_serial_paralelo #(.BC_REQ(BC_REQ), .NUM_LANES(NL)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_out  (lane_out),
        .active    (active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n = 0; anchor = 0; mode = 0; cnt = 0; lane = 0;
        win = '0; e_data = '0; e_valid = 1'b0; e_lane = '0;
    endtask

    task automatic model_step(input logic b);
        win = {win[6:0], b};
        e_valid = 1'b0;
        if (mode == 0) begin
            if (win == BC) begin
                anchor = n; cnt = 1; mode = 1;
            end
        end else if ((n - anchor) % 8 == 0) begin
            if (mode == 1) begin
                if (win == BC) begin
                    cnt++;
                    if (cnt == BC_REQ) mode = 2;
                end else begin
                    cnt = 0; mode = 0;
                end
            end else if (win != BC) begin
                e_data = win; e_valid = 1'b1; e_lane = 2'(lane);
                lane = (lane + 1) % NL;
            end else
                lane = 0;
        end
        n++;
    endtask

    task automatic tick(input logic b);
        data_in = b;
        @(posedge clk);
        if (reset) model_reset(); else model_step(b);
        if (e_valid) pulses++;
        #1;
        check("valid_out", valid_out, e_valid);
        check("active", active, mode == 2);
        check("data_out", data_out, e_data);
        check("lane_out", lane_out, e_lane);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1'($urandom));
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tick(b[i]);
    endtask

    task automatic send_commas(input int k);
        for (int i = 0; i < k; i++) send_byte(BC);
    endtask

    function automatic logic [7:0] rand_data();
        logic [7:0] d;
        d = 8'($urandom);
        return d == BC ? 8'h00 : d;
    endfunction

    initial begin
        model_reset();
        pulses = 0;
        do_reset();
        check("reset_active", active, 1'b0);
        check("reset_data", data_out, 8'h00);
        // Bit-0 aligned commas: lock one clock after the 4th comma LSB, no data
        send_commas(3);
        check("not_yet_active", active, 1'b0);
        send_commas(1);
        check("active_after_4bc", active, 1'b1);
        check("no_pulses_on_commas", pulses, 0);

        do_reset();
        for (int i = 0; i < 3; i++) tick(1'($urandom));
        send_commas(4);
        pulses = 0;
        send_byte(8'hFF); check("byte_ff", data_out, 8'hFF); check("lane0", lane_out, 2'd0);
        send_byte(8'hEE); check("byte_ee", data_out, 8'hEE); check("lane1", lane_out, 2'd1);
        send_byte(8'hDD); check("byte_dd", data_out, 8'hDD); check("lane2", lane_out, 2'd2);
        send_byte(8'hCC); check("byte_cc", data_out, 8'hCC); check("lane3", lane_out, 2'd3);
        check("four_pulses", pulses, 4);

        // Lane wrap, comma resets the stripe
        send_byte(8'hBB); send_byte(8'hAA); send_byte(8'h99); send_byte(8'h88);
        send_byte(8'h77); check("lane_wrap", lane_out, 2'd0);
        pulses = 0;
        send_byte(BC);
        check("comma_no_pulse", pulses, 0);
        check("comma_holds_data", data_out, 8'h77);
        send_byte(8'h55); check("byte_55", data_out, 8'h55); check("lane_after_comma", lane_out, 2'd0);

        // Broken comma run returns to search
        do_reset();
        send_commas(2); send_byte(8'h3C);
        check("sync_broken", active, 1'b0);
        send_commas(3);
        check("still_syncing", active, 1'b0);
        send_commas(1);
        check("relocked", active, 1'b1);
        send_byte(8'h12);

        // Reset mid-byte while active
        for (int i = 7; i >= 4; i--) tick(1'(8'hA5 >> i));
        do_reset();
        check("midbyte_reset_active", active, 1'b0);
        check("midbyte_reset_valid", valid_out, 1'b0);
        check("midbyte_reset_data", data_out, 8'h00);
        pulses = 0;
        send_byte(8'h5A); send_byte(8'h13);
        check("no_data_before_relock", pulses, 0);
        send_commas(4); send_byte(8'h42);
        check("data_after_relock", data_out, 8'h42);

        // Comma-free stream never locks
        do_reset();
        for (int i = 0; i < 40; i++) send_byte(8'hFF);
        check("ff_stream_inactive", active, 1'b0);

        // Randomized sessions
        for (int s = 0; s < 25; s++) begin
            do_reset();
            for (int i = 0; i < int'($urandom_range(0, 7)); i++) tick(1'($urandom));
            send_commas(int'($urandom_range(2, 6)));
            for (int i = 0; i < 30; i++) begin
                if ($urandom_range(0, 9) == 0) send_byte(BC);
                else send_byte(rand_data());
                if ($urandom_range(0, 49) == 0) begin
                    for (int j = 0; j < int'($urandom_range(1, 7)); j++) tick(1'($urandom));
                    do_reset();
                    send_commas(4);
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
